// File: rtl/lat_i2c_seq.sv
// Purpose : one-command sequencer in front of the Lattice I2C master register port.
// Latency : config visible 1 cycle after cmd accept; rx byte forwarded 1 cycle after controller strobe.
// Backpr. : cmd_ready low while busy; tx stalls (tx_ready low) until tx_valid; rx has no backpressure.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cmd_*                        transfer command (valid/ready), rd / 10-bit / address / length
//   tx_data/tx_valid/tx_ready    write-data stream, consumed on a controller request
//   rx_data/rx_valid             read-data stream, 1-cycle pulse per byte
//   done/err                     end-of-command pulse, err qualifies done
//   i_*                          register writes toward the controller
//   o_*                          status/strobes coming back from the controller
module lat_i2c_seq #(
   parameter logic [10:0] CLK_DIV  = 11'd124,
   parameter logic [1:0]  BPS_MODE = 2'd0,
   parameter logic [15:0] TIMEOUT  = 16'd50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_rd,
   input  logic        cmd_a10,
   input  logic [9:0]  cmd_addr,
   input  logic [7:0]  cmd_len,
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic        done,
   output logic        err,
   output logic [9:0]  i_slave_addr_reg,
   output logic [7:0]  i_byte_cnt_reg,
   output logic [7:0]  i_clk_div_lsb,
   output logic [5:0]  i_config_reg,
   output logic [7:0]  i_mode_reg,
   output logic [7:0]  i_transmit_data,
   input  logic [7:0]  o_cmd_status_reg,
   input  logic        o_start_ack,
   input  logic        o_transmit_data_request,
   input  logic        o_received_data_valid,
   input  logic [7:0]  o_receive_data
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CFG   = 3'd1;
   localparam logic [2:0] S_START = 3'd2;
   localparam logic [2:0] S_XFER  = 3'd3;
   localparam logic [2:0] S_ABORT = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   // interrupt enables on, start/abort/soft_reset off
   localparam logic [5:0] CFG_BASE = 6'b001110;

   logic [2:0]  state_q,     state_d;
   logic        cmd_ready_q, cmd_ready_d;
   logic [9:0]  slave_q,     slave_d;
   logic [7:0]  bcnt_q,      bcnt_d;      // doubles as the latched command length
   logic [2:0]  mode_lo_q,   mode_lo_d;   // {adr_mode, rd, ack}
   logic [5:0]  config_q,    config_d;
   logic [7:0]  txd_q,       txd_d;
   logic [7:0]  rxd_q,       rxd_d;
   logic        rxv_q,       rxv_d;
   logic [7:0]  cnt_q,       cnt_d;
   logic [15:0] tmo_q,       tmo_d;
   logic        err_q,       err_d;
   logic        fin_q,       fin_d;       // completion seen, waiting for a last rx byte to go out
   logic        nack_q,      nack_d;

   logic        evt, fwd, fin, nack, do_abort, tmo_hit;
   logic [7:0]  cnt_inc;
   logic        unused_status;

   assign unused_status    = ^o_cmd_status_reg[7:2];

   assign cmd_ready        = cmd_ready_q;
   assign rx_data          = rxd_q;
   assign rx_valid         = rxv_q;
   assign done             = (state_q == S_DONE);
   assign err              = (state_q == S_DONE) & err_q;
   assign i_slave_addr_reg = slave_q;
   assign i_byte_cnt_reg   = bcnt_q;
   assign i_clk_div_lsb    = CLK_DIV[7:0];
   assign i_config_reg     = config_q;
   assign i_mode_reg       = {CLK_DIV[10:8], BPS_MODE, mode_lo_q};
   assign i_transmit_data  = txd_q;

   assign tmo_hit = (tmo_q == TIMEOUT - 16'd1);
   assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      slave_d     = slave_q;
      bcnt_d      = bcnt_q;
      mode_lo_d   = mode_lo_q;
      config_d    = config_q;
      txd_d       = txd_q;
      rxd_d       = rxd_q;
      rxv_d       = 1'b0;
      cnt_d       = cnt_q;
      tmo_d       = tmo_q;
      err_d       = err_q;
      fin_d       = fin_q;
      nack_d      = nack_q;
      tx_ready    = 1'b0;
      evt         = 1'b0;
      fwd         = 1'b0;
      fin         = 1'b0;
      nack        = 1'b0;
      do_abort    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               cnt_d       = 8'd0;
               fin_d       = 1'b0;
               nack_d      = 1'b0;
               if (cmd_len == 8'd0) begin
                  // nothing to transfer: report error without touching the controller
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  err_d     = 1'b0;
                  slave_d   = cmd_a10 ? cmd_addr : {3'b000, cmd_addr[6:0]};
                  bcnt_d    = cmd_len;
                  mode_lo_d = {cmd_a10, cmd_rd, 1'b1};
                  config_d  = CFG_BASE;
                  state_d   = S_CFG;
               end
            end
         end
         S_CFG: begin
            config_d[0] = 1'b1;
            tmo_d       = 16'd0;
            state_d     = S_START;
         end
         S_START: begin
            if (o_start_ack) begin
               config_d[0] = 1'b0;
               tmo_d       = 16'd0;
               state_d     = S_XFER;
            end else if (tmo_hit) begin
               do_abort = 1'b1;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         S_XFER: begin
            if (!mode_lo_q[1]) begin
               if (o_transmit_data_request && tx_valid) begin
                  tx_ready = 1'b1;
                  txd_d    = tx_data;
                  cnt_d    = cnt_inc;
                  evt      = 1'b1;
               end
            end else if (o_received_data_valid) begin
               evt = 1'b1;
               // bytes past the requested length are swallowed
               if (cnt_q != bcnt_q) begin
                  rxd_d = o_receive_data;
                  rxv_d = 1'b1;
                  cnt_d = cnt_inc;
                  fwd   = 1'b1;
               end
            end
            fin  = o_cmd_status_reg[0] | fin_q;
            nack = o_cmd_status_reg[1] | nack_q;
            // a byte forwarded this cycle must pulse rx_valid before done
            if (fin && !fwd) begin
               err_d   = nack | (cnt_d != bcnt_q);
               state_d = S_DONE;
            end else begin
               fin_d  = fin;
               nack_d = nack;
               if (evt)          tmo_d    = 16'd0;
               else if (tmo_hit) do_abort = 1'b1;
               else              tmo_d    = tmo_q + 16'd1;
            end
         end
         S_ABORT: begin
            config_d[4] = 1'b0;
            err_d       = 1'b1;
            state_d     = S_DONE;
         end
         S_DONE: begin
            config_d    = 6'd0;
            cmd_ready_d = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (do_abort) begin
         config_d[4] = 1'b1;
         config_d[0] = 1'b0;
         state_d     = S_ABORT;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cmd_ready_q <= 1'b1;
         slave_q     <= 10'd0;
         bcnt_q      <= 8'd0;
         mode_lo_q   <= 3'd0;
         config_q    <= 6'd0;
         txd_q       <= 8'd0;
         rxd_q       <= 8'd0;
         rxv_q       <= 1'b0;
         cnt_q       <= 8'd0;
         tmo_q       <= 16'd0;
         err_q       <= 1'b0;
         fin_q       <= 1'b0;
         nack_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         slave_q     <= slave_d;
         bcnt_q      <= bcnt_d;
         mode_lo_q   <= mode_lo_d;
         config_q    <= config_d;
         txd_q       <= txd_d;
         rxd_q       <= rxd_d;
         rxv_q       <= rxv_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         err_q       <= err_d;
         fin_q       <= fin_d;
         nack_q      <= nack_d;
      end
   end

endmodule
